// File: rtl/alu_arbiter_3bit.sv
// Round-robin arbiter sharing one 3-bit ALU (add/sub/AND/OR) between two requesters.
// Operands are registered before the ALU and results after it, so the response is held stable.
module alu_arbiter_3bit #(
  parameter logic RESET_PRIO = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       r0_valid,
  output logic       r0_ready,
  input  logic [2:0] r0_a,
  input  logic [2:0] r0_b,
  input  logic [1:0] r0_sel,
  input  logic       r1_valid,
  output logic       r1_ready,
  input  logic [2:0] r1_a,
  input  logic [2:0] r1_b,
  input  logic [1:0] r1_sel,
  output logic       resp_valid,
  input  logic       resp_ready,
  output logic       resp_id,
  output logic [2:0] resp_y,
  output logic       resp_cout,
  output logic       busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] RESP = 2'd2;

  logic [1:0] state_q, state_d;
  logic       prio_q, prio_d;
  logic [2:0] opA_q, opA_d;
  logic [2:0] opB_q, opB_d;
  logic [1:0] opSel_q, opSel_d;
  logic       opId_q, opId_d;
  logic [2:0] respY_q, respY_d;
  logic       respCout_q, respCout_d;
  logic       respId_q, respId_d;

  logic       grantValid;
  logic       grantId;
  logic [2:0] bOperand;
  logic [3:0] sum;
  logic [2:0] aluY;
  logic       aluCout;

  // Ties go to prio; a lone requester wins regardless of prio.
  always_comb begin
    grantValid = 1'b0;
    grantId    = 1'b0;
    if (state_q == IDLE && !rst) begin
      if (r0_valid && r1_valid) begin
        grantValid = 1'b1;
        grantId    = prio_q;
      end else if (r0_valid) begin
        grantValid = 1'b1;
        grantId    = 1'b0;
      end else if (r1_valid) begin
        grantValid = 1'b1;
        grantId    = 1'b1;
      end
    end
  end

  assign r0_ready = grantValid && !grantId;
  assign r1_ready = grantValid && grantId;

  // Subtract is A + ~B + 1, so carry-out means "no borrow".
  always_comb begin
    bOperand = (opSel_q == 2'b01) ? ~opB_q : opB_q;
    sum      = {1'b0, opA_q} + {1'b0, bOperand} + {3'b000, (opSel_q == 2'b01)};
    aluY     = sum[2:0];
    aluCout  = sum[3];
    case (opSel_q)
      2'b10: begin
        aluY    = opA_q & opB_q;
        aluCout = 1'b0;
      end
      2'b11: begin
        aluY    = opA_q | opB_q;
        aluCout = 1'b0;
      end
      default: begin
        aluY    = sum[2:0];
        aluCout = sum[3];
      end
    endcase
  end

  always_comb begin
    state_d    = state_q;
    prio_d     = prio_q;
    opA_d      = opA_q;
    opB_d      = opB_q;
    opSel_d    = opSel_q;
    opId_d     = opId_q;
    respY_d    = respY_q;
    respCout_d = respCout_q;
    respId_d   = respId_q;
    case (state_q)
      IDLE: begin
        if (grantValid) begin
          opA_d   = grantId ? r1_a : r0_a;
          opB_d   = grantId ? r1_b : r0_b;
          opSel_d = grantId ? r1_sel : r0_sel;
          opId_d  = grantId;
          state_d = EXEC;
        end
      end
      EXEC: begin
        respY_d    = aluY;
        respCout_d = aluCout;
        respId_d   = opId_q;
        state_d    = RESP;
      end
      RESP: begin
        if (resp_ready) begin
          prio_d  = ~respId_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      prio_q     <= RESET_PRIO;
      opA_q      <= 3'd0;
      opB_q      <= 3'd0;
      opSel_q    <= 2'd0;
      opId_q     <= 1'b0;
      respY_q    <= 3'd0;
      respCout_q <= 1'b0;
      respId_q   <= 1'b0;
    end else begin
      state_q    <= state_d;
      prio_q     <= prio_d;
      opA_q      <= opA_d;
      opB_q      <= opB_d;
      opSel_q    <= opSel_d;
      opId_q     <= opId_d;
      respY_q    <= respY_d;
      respCout_q <= respCout_d;
      respId_q   <= respId_d;
    end
  end

  assign resp_valid = (state_q == RESP);
  assign resp_id    = respId_q;
  assign resp_y     = respY_q;
  assign resp_cout  = respCout_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_alu_arbiter_3bit.sv
// Directed bench for alu_arbiter_3bit: single ops, ties, backpressure, late operand
// changes and reset in the middle of an operation.
module tb_alu_arbiter_3bit;

  logic       clk;
  logic       rst;
  logic       r0_valid, r0_ready;
  logic [2:0] r0_a, r0_b;
  logic [1:0] r0_sel;
  logic       r1_valid, r1_ready;
  logic [2:0] r1_a, r1_b;
  logic [1:0] r1_sel;
  logic       resp_valid, resp_ready, resp_id, resp_cout, busy;
  logic [2:0] resp_y;

  int compareCount = 0;
  int failCount = 0;

  alu_arbiter_3bit #(.RESET_PRIO(1'b0)) dut (
    .clk(clk), .rst(rst),
    .r0_valid(r0_valid), .r0_ready(r0_ready), .r0_a(r0_a), .r0_b(r0_b), .r0_sel(r0_sel),
    .r1_valid(r1_valid), .r1_ready(r1_ready), .r1_a(r1_a), .r1_b(r1_b), .r1_sel(r1_sel),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_id(resp_id),
    .resp_y(resp_y), .resp_cout(resp_cout), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compareCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; checks happen 1 unit later.
  task automatic nextCycle;
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic v0, input logic [2:0] a0, input logic [2:0] b0,
                               input logic [1:0] s0, input logic v1, input logic [2:0] a1,
                               input logic [2:0] b1, input logic [1:0] s1, input logic rr);
    r0_valid = v0; r0_a = a0; r0_b = b0; r0_sel = s0;
    r1_valid = v1; r1_a = a1; r1_b = b1; r1_sel = s1;
    resp_ready = rr;
    #1;
  endtask

  // One complete operation from IDLE with resp_ready held high.
  task automatic doOp(input logic id, input logic [2:0] a, input logic [2:0] b,
                      input logic [1:0] sel, input logic [2:0] expY, input logic expCout);
    applyStimulus(!id, a, b, sel, id, a, b, sel, 1'b1);
    checkOutput("opReady", {6'd0, r1_ready, r0_ready}, id ? 8'd2 : 8'd1);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 3'd0, 2'd0, 1'b0, 3'd0, 3'd0, 2'd0, 1'b1);
    checkOutput("opExecBusy", {7'd0, busy}, 8'd1);
    nextCycle();
    checkOutput("opRespValid", {7'd0, resp_valid}, 8'd1);
    checkOutput("opRespY", {5'd0, resp_y}, {5'd0, expY});
    checkOutput("opRespCout", {7'd0, resp_cout}, {7'd0, expCout});
    checkOutput("opRespId", {7'd0, resp_id}, {7'd0, id});
    nextCycle();
    checkOutput("opIdle", {6'd0, busy, resp_valid}, 8'd0);
  endtask

  initial begin
    // Reset with a request pending: no ready may appear while rst is high.
    rst = 1'b1;
    applyStimulus(1'b1, 3'd3, 3'd2, 2'b00, 1'b1, 3'd1, 3'd1, 2'b00, 1'b1);
    checkOutput("readyInReset", {6'd0, r1_ready, r0_ready}, 8'd0);
    nextCycle();
    nextCycle();
    checkOutput("resetValid", {7'd0, resp_valid}, 8'd0);
    checkOutput("resetBusy", {7'd0, busy}, 8'd0);
    checkOutput("resetY", {5'd0, resp_y}, 8'd0);
    checkOutput("resetCoutId", {6'd0, resp_cout, resp_id}, 8'd0);
    rst = 1'b0;

    $display("[TB] single op and arithmetic cases");
    doOp(1'b0, 3'd3, 3'd2, 2'b00, 3'd5, 1'b0);
    doOp(1'b0, 3'd7, 3'd1, 2'b00, 3'd0, 1'b1);
    doOp(1'b0, 3'd2, 3'd3, 2'b01, 3'd7, 1'b0);
    doOp(1'b1, 3'd5, 3'd3, 2'b10, 3'd1, 1'b0);
    doOp(1'b1, 3'd5, 3'd3, 2'b11, 3'd7, 1'b0);
    doOp(1'b0, 3'd6, 3'd3, 2'b01, 3'd3, 1'b1);

    $display("[TB] backpressure");
    applyStimulus(1'b1, 3'd6, 3'd5, 2'b00, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0);
    checkOutput("bpAccept", {6'd0, r1_ready, r0_ready}, 8'd1);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 3'd0, 2'b00, 1'b1, 3'd4, 3'd4, 2'b00, 1'b0);
    nextCycle();
    for (int i = 0; i < 5; i++) begin
      checkOutput("bpHold", {resp_valid, resp_y, resp_cout, resp_id, busy, 1'b0}, 8'b1_011_1_0_1_0);
      checkOutput("bpReady", {6'd0, r1_ready, r0_ready}, 8'd0);
      nextCycle();
    end
    resp_ready = 1'b1;
    #1;
    checkOutput("bpHandshakeNoAccept", {6'd0, r1_ready, r0_ready}, 8'd0);
    nextCycle();
    checkOutput("bpReleased", {6'd0, busy, resp_valid}, 8'd0);

    $display("[TB] operand change after accept");
    checkOutput("lateAccept", {6'd0, r1_ready, r0_ready}, 8'd2);
    nextCycle();
    r1_a = 3'd1;
    r1_valid = 1'b0;
    nextCycle();
    checkOutput("lateResp", {4'd0, resp_y, resp_cout}, {4'd0, 3'd0, 1'b1});
    checkOutput("lateId", {7'd0, resp_id}, 8'd1);
    nextCycle();

    // Serve r0 so prio points at r1 before the mid-op resets.
    doOp(1'b0, 3'd1, 3'd2, 2'b00, 3'd3, 1'b0);

    $display("[TB] reset mid-op");
    applyStimulus(1'b1, 3'd3, 3'd3, 2'b00, 1'b0, 3'd0, 3'd0, 2'b00, 1'b1);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 3'd0, 3'd0, 2'b00, 1'b1);
    rst = 1'b1;
    nextCycle();
    checkOutput("rstExec", {6'd0, busy, resp_valid}, 8'd0);
    rst = 1'b0;
    nextCycle();
    checkOutput("rstExecNoStale", {4'd0, resp_valid, busy, resp_cout, 1'b0}, 8'd0);
    checkOutput("rstExecY", {5'd0, resp_y}, 8'd0);

    applyStimulus(1'b0, 3'd0, 3'd0, 2'b00, 1'b1, 3'd7, 3'd7, 2'b00, 1'b0);
    nextCycle();
    applyStimulus(1'b0, 3'd0, 3'd0, 2'b00, 1'b0, 3'd0, 3'd0, 2'b00, 1'b0);
    nextCycle();
    checkOutput("preRstResp", {resp_valid, resp_y, resp_cout, resp_id, 2'b00}, 8'b1_110_1_1_00);
    rst = 1'b1;
    nextCycle();
    checkOutput("rstResp", {6'd0, busy, resp_valid}, 8'd0);
    checkOutput("rstRespRegs", {3'd0, resp_y, resp_cout, resp_id}, 8'd0);
    rst = 1'b0;
    resp_ready = 1'b1;
    nextCycle();
    checkOutput("rstRespNoStale", {6'd0, busy, resp_valid}, 8'd0);

    $display("[TB] tie and fairness");
    applyStimulus(1'b1, 3'd1, 3'd1, 2'b00, 1'b1, 3'd6, 3'd3, 2'b01, 1'b1);
    for (int k = 0; k < 4; k++) begin
      logic expId;
      expId = k[0];
      checkOutput("tieGrant", {6'd0, r1_ready, r0_ready}, expId ? 8'd2 : 8'd1);
      nextCycle();
      checkOutput("tieExecReady", {6'd0, r1_ready, r0_ready}, 8'd0);
      nextCycle();
      checkOutput("tieRespId", {7'd0, resp_id}, {7'd0, expId});
      checkOutput("tieRespY", {4'd0, resp_y, resp_cout}, expId ? 8'b0000_0111 : 8'b0000_0100);
      checkOutput("tieRespReady", {6'd0, r1_ready, r0_ready}, 8'd0);
      nextCycle();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule

// File: doc/alu_arbiter_3bit.md
Name: alu_arbiter_3bit

Overview:
Shares one instance of the team's 3-bit ALU (alu_top_3bit: add/sub/AND/OR, sel 00/01/10/11) between two requesters. Arbitration is round-robin, with valid/ready on each request side and on the single response side. Operands are registered before the ALU and results are registered after it, so the response is glitch-free and held stable. The block sits between the two operand sources in the top-level design and the shared ALU datapath.

Parameters:
RESET_PRIO, 0, requester that has priority after reset (0 or 1).

Ports:
clk  input  1  system clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
r0_valid  input  1  requester 0 has an operation pending
r0_ready  output  1  requester 0 operation accepted this cycle
r0_a  input  3  requester 0 operand A
r0_b  input  3  requester 0 operand B
r0_sel  input  2  requester 0 ALU op (00 add, 01 sub, 10 AND, 11 OR)
r1_valid, r1_ready, r1_a, r1_b, r1_sel  same as requester 0, for requester 1
resp_valid  output  1  result available
resp_ready  input  1  consumer takes the result
resp_id  output  1  requester that issued this result
resp_y  output  3  ALU result
resp_cout  output  1  ALU carry-out (add/sub only; 0 for AND/OR)
busy  output  1  high whenever state is not IDLE

Behaviour:
- Synchronous reset (rst=1 at a clock edge):
  - state=IDLE, prio=RESET_PRIO.
  - resp_valid=0, resp_id=0, resp_y=0, resp_cout=0, busy=0.
  - Operand registers cleared to 0.
  - Any in-flight operation is discarded silently and no response is produced.
- r0_ready and r1_ready are combinational. They are asserted only in IDLE, and at most one of them per cycle. Both are 0 while rst=1.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - If exactly one rX_valid=1, that requester is granted.
  - If both are valid, the requester equal to prio is granted.
  - The winner's ready=1 that cycle. At the clock edge, its a/b/sel and id are latched and the FSM moves to EXEC.
  - If no request is valid, the FSM stays in IDLE.
- EXEC:
  - The ALU is driven from the latched operands.
  - At the edge, Y is captured into resp_y and Cout into resp_cout, the id into resp_id, and the FSM moves to RESP.
  - Requests are not accepted in this state.
- RESP:
  - resp_valid=1; resp_y, resp_cout and resp_id are held stable.
  - When resp_ready=1 at an edge: move to IDLE and set prio = ~resp_id, so the requester just served loses priority.
  - While resp_ready=0, all outputs are held indefinitely (backpressure).
- Timing:
  - Accept at edge N gives resp_valid=1 from cycle N+2.
  - Minimum spacing between accepts is 3 cycles (accept, EXEC, RESP with immediate resp_ready).
  - No new accept occurs in the same cycle as a response handshake; the next accept comes in the following IDLE cycle.
- Arithmetic is 3-bit modulo 2^3.
  - Add: Cout = carry out of bit 2.
  - Sub: A + ~B + 1, so Cout=1 means no borrow (A>=B unsigned).
- Requester side: a requester must hold its valid and operands stable until it sees ready. The block samples operands only on the accept edge. Operand changes after acceptance do not affect the result.
- A requester that keeps valid high continuously while the other is idle is served back-to-back every 3 cycles. prio only decides ties.
- busy = (state != IDLE).

Test Plan:
- Reset then single op: rst high for 2 cycles, then r0 requests a=3 b=2 sel=00 with resp_ready=1 → r0_ready in cycle 0; resp_valid in cycle 2 with resp_y=5, resp_cout=0, resp_id=0; back to IDLE in cycle 3.
- Wrap and subtract: a=7 b=1 sel=00 → y=0, cout=1. a=2 b=3 sel=01 → y=7, cout=0. a=5 b=3 sel=10 → y=1, cout=0. a=5 b=3 sel=11 → y=7, cout=0.
- Tie and fairness: r0 and r1 both hold valid for 4 ops with resp_ready=1 and RESET_PRIO=0 → grant order is 0, 1, 0, 1; r0_ready and r1_ready are never high together.
- Backpressure: hold resp_ready=0 for 5 cycles in RESP → resp_y, resp_cout and resp_id are stable, both readys stay 0 and busy=1. Releasing resp_ready → IDLE on the next edge.
- Operand change after accept: r1 is accepted with a=4 b=4 sel=00, then r1_a changes to 1 in EXEC → resp_y=0, resp_cout=1.
- Reset mid-op: assert rst in EXEC and again in RESP → the next cycle shows resp_valid=0, busy=0, prio=RESET_PRIO, and no stale response ever appears.
